// File: rtl/mmio_arb2_if.sv
// Bus bundle for mmio_arb2: two requester channels, their responses, and the
// single downstream MMIO peripheral port.
interface mmio_arb2_if #(
    parameter int ADDR_W = 12
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_we;
    logic [1:0]          req_lock;
    logic [2*ADDR_W-1:0] req_addr;
    logic [63:0]         req_wdata;
    logic [7:0]          req_wstrb;

    logic [1:0]          resp_valid;
    logic [1:0]          resp_ready;
    logic [31:0]         resp_rdata;

    logic                mmio_valid;
    logic                mmio_we;
    logic [ADDR_W-1:0]   mmio_addr;
    logic [31:0]         mmio_wdata;
    logic [3:0]          mmio_wstrb;
    logic                mmio_ready;
    logic [31:0]         mmio_rdata;

    // Arbiter side
    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata, req_wstrb,
        input  resp_ready, mmio_ready, mmio_rdata,
        output req_ready, resp_valid, resp_rdata,
        output mmio_valid, mmio_we, mmio_addr, mmio_wdata, mmio_wstrb
    );

    // Requesters plus peripheral, as seen from outside the arbiter
    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata, req_wstrb,
        output resp_ready, mmio_ready, mmio_rdata,
        input  req_ready, resp_valid, resp_rdata,
        input  mmio_valid, mmio_we, mmio_addr, mmio_wdata, mmio_wstrb
    );
endinterface

// File: rtl/mmio_arb2.sv
// Two-requester round-robin MMIO arbiter, one transaction outstanding.
// Optional grant locking is enabled by defining MMIO_ARB_LOCK_EN.
module mmio_arb2 #(
    parameter int ADDR_W = 12
) (
    input logic        clk,
    input logic        rst_n,
    mmio_arb2_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        rr_q, rr_d;
    logic        gnt_id_q, gnt_id_d;
    logic        we_q, we_d;
    logic [31:0] rdata_q, rdata_d;
    logic        lock_q;
    logic        lock_id_q;

    logic [1:0]  elig;
    logic        win;
    logic        accept;

    // A held lock masks off the other requester entirely
    always_comb begin
        elig = bus.req_valid;
        if (lock_q) begin
            elig = bus.req_valid & (lock_id_q ? 2'b10 : 2'b01);
        end
        win = 1'b0;
        case (elig)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = rr_q;
            default: win = 1'b0;
        endcase
    end

    // With no eligible requester, win stays 0 so fields follow requester 0
    assign bus.mmio_addr  = win ? bus.req_addr[ADDR_W +: ADDR_W] : bus.req_addr[0 +: ADDR_W];
    assign bus.mmio_wdata = win ? bus.req_wdata[32 +: 32]        : bus.req_wdata[0 +: 32];
    assign bus.mmio_wstrb = win ? bus.req_wstrb[4 +: 4]          : bus.req_wstrb[0 +: 4];
    assign bus.mmio_we    = win ? bus.req_we[1]                  : bus.req_we[0];
    assign bus.resp_rdata = rdata_q;

    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        gnt_id_d       = gnt_id_q;
        we_d           = we_q;
        rdata_d        = rdata_q;
        accept         = 1'b0;
        bus.mmio_valid = 1'b0;
        bus.req_ready  = 2'b00;
        bus.resp_valid = 2'b00;
        case (state_q)
            IDLE: begin
                bus.mmio_valid = |elig;
                if ((|elig) && bus.mmio_ready) begin
                    bus.req_ready = win ? 2'b10 : 2'b01;
                    accept        = 1'b1;
                    state_d       = CAPT;
                    gnt_id_d      = win;
                    we_d          = bus.mmio_we;
                    rr_d          = ~win;
                end
            end
            CAPT: begin
                rdata_d = we_q ? 32'h0 : bus.mmio_rdata;
                state_d = RESP;
            end
            RESP: begin
                bus.resp_valid = gnt_id_q ? 2'b10 : 2'b01;
                if (bus.resp_ready[gnt_id_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_q     <= 1'b0;
            gnt_id_q <= 1'b0;
            we_q     <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gnt_id_q <= gnt_id_d;
            we_q     <= we_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef MMIO_ARB_LOCK_EN
    logic lock_d, lock_id_d;

    // Every accept re-evaluates the lock from the winner's own req_lock bit
    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (accept) begin
            lock_d    = bus.req_lock[win];
            lock_id_d = win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end
`else
    logic unused_lock;

    assign lock_q      = 1'b0;
    assign lock_id_q   = 1'b0;
    assign unused_lock = ^{bus.req_lock, accept};
`endif

endmodule
